// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned XLEN = 32;

    // Refill controller states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Word read request presented to instruction memory
    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] addr;
    } mem_req_t;

    // Word-offset width within a line
    function automatic int unsigned f_ow_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Line-index width
    function automatic int unsigned f_idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: what is left of the word address above offset and index
    function automatic int unsigned f_tag_bits(input int unsigned ow, input int unsigned iw);
        return XLEN - 2 - ow - iw;
    endfunction

    // Word offset within the line, right-aligned
    function automatic logic [XLEN-1:0] f_offset(input logic [XLEN-1:0] addr, input int unsigned ow);
        return (addr >> 2) & ((XLEN'(1) << ow) - XLEN'(1));
    endfunction

    // Line index, right-aligned
    function automatic logic [XLEN-1:0] f_index(input logic [XLEN-1:0] addr, input int unsigned ow,
                                                input int unsigned iw);
        return (addr >> (2 + ow)) & ((XLEN'(1) << iw) - XLEN'(1));
    endfunction

    // Tag, right-aligned
    function automatic logic [XLEN-1:0] f_tag(input logic [XLEN-1:0] addr, input int unsigned ow,
                                              input int unsigned iw);
        return addr >> (2 + ow + iw);
    endfunction

    // Byte address of word 0 of the line holding addr
    function automatic logic [XLEN-1:0] f_line_base(input logic [XLEN-1:0] addr, input int unsigned ow);
        return addr & ~((XLEN'(1) << (ow + 2)) - XLEN'(1));
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill controller: owns the IDLE/REFILL state, word counter, latched
// line base, deferred-invalidate flag and the word-at-a-time memory handshake.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned OW         = f_ow_bits(LINE_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_line_base,
    input  logic            i_inv,
    input  logic            i_mem_ack,
    output state_e          o_state,
    output logic [OW-1:0]   o_cnt,
    output logic [XLEN-1:0] o_line_base,
    output logic            o_inv_pend,
    output mem_req_t        o_mem_c,
    output logic            o_wr_en_c,
    output logic            o_last_c
);

    localparam logic [OW-1:0] CNT_LAST = OW'(LINE_WORDS - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [OW-1:0]   r_cnt;
    logic [OW-1:0]   w_cnt_nxt;
    logic [XLEN-1:0] r_line_base;
    logic [XLEN-1:0] w_base_nxt;
    logic            r_inv_pend;
    logic            w_pend_nxt;

    // State and refill-context registers; reset abandons any refill at once
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line_base <= '0;
            r_inv_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_line_base <= w_base_nxt;
            r_inv_pend  <= w_pend_nxt;
        end
    end

    // Next-state and handshake decode; words are fetched strictly in order from offset 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_base_nxt  = r_line_base;
        w_pend_nxt  = r_inv_pend;
        o_mem_c     = '0;
        o_wr_en_c   = 1'b0;
        o_last_c    = 1'b0;
        case (r_state)
            IDLE: begin
                w_pend_nxt = 1'b0;
                if (i_start) begin
                    w_state_nxt = REFILL;
                    w_cnt_nxt   = '0;
                    w_base_nxt  = i_line_base;
                end
            end
            REFILL: begin
                o_mem_c.req  = 1'b1;
                o_mem_c.addr = r_line_base + (XLEN'(r_cnt) << 2);
                if (i_inv) begin
                    w_pend_nxt = 1'b1;
                end
                if (i_mem_ack) begin
                    o_wr_en_c = 1'b1;
                    w_cnt_nxt = r_cnt + OW'(1);
                    if (r_cnt == CNT_LAST) begin
                        o_last_c    = 1'b1;
                        w_state_nxt = IDLE;
                        w_pend_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_state     = r_state;
    assign o_cnt       = r_cnt;
    assign o_line_base = r_line_base;
    assign o_inv_pend  = r_inv_pend;

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line
// refill on a miss with stall_o held until the line is back.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            inv_i,
    output logic [XLEN-1:0] instr_o,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i,
    output logic [XLEN-1:0] hit_cnt_o,
    output logic [XLEN-1:0] miss_cnt_o
);

    localparam int unsigned OW = f_ow_bits(LINE_WORDS);
    localparam int unsigned IW = f_idx_bits(NUM_LINES);
    localparam int unsigned TW = f_tag_bits(OW, IW);

    // Line storage: valid bits are reset, tags and data are not
    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [XLEN-1:0]      r_data [NUM_LINES][LINE_WORDS];

    logic [OW-1:0]   w_off;
    logic [IW-1:0]   w_idx;
    logic [TW-1:0]   w_tag;
    logic [XLEN-1:0] w_line_base;
    logic            w_lookup_hit;
    logic            w_idle;
    logic            w_hit;
    logic            w_start;

    state_e          w_state;
    logic [OW-1:0]   w_cnt;
    logic [XLEN-1:0] w_fill_base;
    logic [IW-1:0]   w_fill_idx;
    logic [TW-1:0]   w_fill_tag;
    logic            w_inv_pend;
    mem_req_t        w_mem;
    logic            w_wr_en;
    logic            w_last;

    // Lookup address split
    assign w_off       = OW'(f_offset(pc_i, OW));
    assign w_idx       = IW'(f_index(pc_i, OW, IW));
    assign w_tag       = TW'(f_tag(pc_i, OW, IW));
    assign w_line_base = f_line_base(pc_i, OW);

    // Refill target fields come from the latched line base, not the live PC
    assign w_fill_idx  = IW'(f_index(w_fill_base, OW, IW));
    assign w_fill_tag  = TW'(f_tag(w_fill_base, OW, IW));

    // Hit detection; lookups only count while no refill is in flight
    assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle       = (w_state == IDLE);
    assign w_hit        = req_i && w_idle && w_lookup_hit;
    assign w_start      = req_i && w_idle && !w_lookup_hit;

    assign stall_o    = req_i && (!w_idle || !w_lookup_hit);
    assign instr_o    = w_hit ? r_data[w_idx][w_off] : '0;
    assign mem_req_o  = w_mem.req;
    assign mem_addr_o = w_mem.addr;

    icache_refill_fsm #(
        .LINE_WORDS (LINE_WORDS),
        .OW         (OW)
    ) u_refill (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_start     (w_start),
        .i_line_base (w_line_base),
        .i_inv       (inv_i),
        .i_mem_ack   (mem_ack_i),
        .o_state     (w_state),
        .o_cnt       (w_cnt),
        .o_line_base (w_fill_base),
        .o_inv_pend  (w_inv_pend),
        .o_mem_c     (w_mem),
        .o_wr_en_c   (w_wr_en),
        .o_last_c    (w_last)
    );

    // Valid bits: invalidate clears all; a finished refill validates its line
    // unless an invalidate arrived at any point during that refill
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= '0;
        end else begin
            if (inv_i) begin
                r_valid <= '0;
            end
            if (w_last && !inv_i && !w_inv_pend) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Refill data and tag capture
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_data[w_fill_idx][w_cnt] <= mem_rdata_i;
        end
        if (w_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [XLEN-1:0] r_hit_cnt;
    logic [XLEN-1:0] r_miss_cnt;

    // Saturating hit/miss statistics
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + XLEN'(1);
            end
            if (w_start && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + XLEN'(1);
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a per-cycle vector table for hits,
// misses, conflicts and invalidates, plus sequences for wait states,
// reset during refill and the statistics counters.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        inv = 1'b0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ICACHE_STATS_EN
    localparam logic [31:0] EXP_HITS   = 32'd3;
    localparam logic [31:0] EXP_MISSES = 32'd1;
`else
    localparam logic [31:0] EXP_HITS   = 32'd0;
    localparam logic [31:0] EXP_MISSES = 32'd0;
`endif

    icache_direct dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .pc_i        (pc),
        .inv_i       (inv),
        .instr_o     (instr),
        .stall_o     (stall),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack),
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory contents: word at 0x40 is 0xA0, each following word one higher
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h90;
    endfunction

    // Memory responder: ack once every (wait_n+1) request cycles
    int          wait_n = 0;
    logic        ack_force = 1'b0;
    int          wcnt = 0;
    int          addr_glitch = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] acked_q[$];

    always @(negedge clk) begin
        if (mem_req && prev_req && !prev_ack && (mem_addr !== prev_addr)) addr_glitch++;
        if (ack_force) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (mem_req) begin
            if (wcnt >= wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                acked_q.push_back(mem_addr);
                wcnt      = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        inv;
        logic        exp_stall;
        logic [31:0] exp_instr;
        logic        exp_mreq;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [31:0] a, input logic iv, input logic s,
                           input logic [31:0] ins, input logic mr, input logic [31:0] ma);
        vec_t v;
        v.req = r; v.pc = a; v.inv = iv;
        v.exp_stall = s; v.exp_instr = ins; v.exp_mreq = mr; v.exp_maddr = ma;
        vecs.push_back(v);
    endtask

    // Miss cycle followed by four zero-wait refill cycles; pc_during is driven
    // while refilling and must be ignored; inv_word pulses inv on that word
    task automatic add_miss(input logic [31:0] a, input logic [31:0] pc_during, input int inv_word,
                            input logic inv_miss);
        logic [31:0] base;
        base = a & ~32'hF;
        add_vec(1'b1, a, inv_miss, 1'b1, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++)
            add_vec(1'b1, pc_during, (k == inv_word), 1'b1, 32'h0, 1'b1, base + 32'(4 * k));
    endtask

    task automatic add_hit(input logic [31:0] a, input logic iv);
        add_vec(1'b1, a, iv, 1'b0, mem_word(a & ~32'h3), 1'b0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset state: nothing valid, so a request stalls
        req = 1'b1; pc = 32'h40;
        #2;
        chk("rst_stall",    0, 32'(stall),    32'h1);
        chk("rst_instr",    0, instr,         32'h0);
        chk("rst_mem_req",  0, 32'(mem_req),  32'h0);
        chk("rst_mem_addr", 0, mem_addr,      32'h0);
        chk("rst_hit_cnt",  0, hit_cnt,       32'h0);
        chk("rst_miss_cnt", 0, miss_cnt,      32'h0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        add_miss(32'h40, 32'h40, -1, 1'b0);           // cold miss, 5 stall cycles
        add_hit(32'h40, 1'b0);
        add_hit(32'h4C, 1'b0);
        add_vec(1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        add_miss(32'h140, 32'h40, -1, 1'b0);          // conflict; PC changes mid-refill
        add_hit(32'h140, 1'b0);
        add_miss(32'h40, 32'h40, -1, 1'b0);           // evicted line misses again
        add_hit(32'h40, 1'b0);
        add_vec(1'b0, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);  // invalidate in IDLE
        add_miss(32'h40, 32'h40, -1, 1'b0);
        add_hit(32'h40, 1'b0);
        add_hit(32'h44, 1'b1);                        // hit still served while invalidating
        add_miss(32'h44, 32'h44, 1, 1'b0);            // invalidate during refill
        add_miss(32'h44, 32'h44, -1, 1'b0);           // line left invalid
        add_hit(32'h44, 1'b0);
        add_miss(32'h200, 32'h200, -1, 1'b1);         // invalidate together with a miss
        add_hit(32'h200, 1'b0);
        add_miss(32'h40, 32'h40, -1, 1'b0);
        add_hit(32'h40, 1'b0);
        add_miss(32'h140, 32'h140, 3, 1'b0);          // invalidate on the final ack
        add_miss(32'h140, 32'h140, -1, 1'b0);
        add_hit(32'h140, 1'b0);
        add_miss(32'h200, 32'h200, -1, 1'b0);
        add_hit(32'h204, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            req = vecs[i].req; pc = vecs[i].pc; inv = vecs[i].inv;
            @(negedge clk);
            chk("stall",    i, 32'(stall),   32'(vecs[i].exp_stall));
            chk("instr",    i, instr,        vecs[i].exp_instr);
            chk("mem_req",  i, 32'(mem_req), 32'(vecs[i].exp_mreq));
            chk("mem_addr", i, mem_addr,     vecs[i].exp_maddr);
        end
        @(posedge clk); #1;
        req = 1'b0; inv = 1'b0;

        // Wait states: ack every third cycle, 4*3 refill cycles plus the miss cycle
        wait_n = 2;
        acked_q.delete();
        @(posedge clk); #1;
        req = 1'b1; pc = 32'h80;
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall) break;
            cyc++;
            @(posedge clk); #1;
        end
        chk("ws_stall_cycles", 0, 32'(cyc), 32'd13);
        chk("ws_instr",        0, instr,    32'hB0);
        chk("ws_ack_count",    0, 32'(acked_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] got;
            got = (k < acked_q.size()) ? acked_q[k] : 32'hFFFF_FFFF;
            chk("ws_ack_addr", k, got, 32'h80 + 32'(4 * k));
        end
        chk("addr_stable", 0, 32'(addr_glitch), 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        wait_n = 0;

        // Reset after the second ack of a refill
        @(posedge clk); #1;
        req = 1'b1; pc = 32'h300;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_mem_addr", 0, mem_addr, 32'h308);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req",  0, 32'(mem_req), 32'h0);
        chk("mid_rst_mem_addr", 0, mem_addr,     32'h0);
        chk("mid_rst_stall",    0, 32'(stall),   32'h1);
        ack_force = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        ack_force = 1'b0;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 0x40 misses after reset; then one miss and three hit cycles for the counters
        @(posedge clk); #1;
        req = 1'b1; pc = 32'h40;
        @(negedge clk);
        chk("post_rst_stall",   0, 32'(stall),   32'h1);
        chk("post_rst_mem_req", 0, 32'(mem_req), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("post_rst_refill", k, mem_addr, 32'h40 + 32'(4 * k));
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            pc = 32'h40 + 32'(4 * k);
            @(negedge clk);
            chk("stats_hit_stall", k, 32'(stall), 32'h0);
            chk("stats_hit_instr", k, instr, 32'hA0 + 32'(k));
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("hit_cnt",  0, hit_cnt,  EXP_HITS);
        chk("miss_cnt", 0, miss_cnt, EXP_MISSES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
